// File: rtl/cas_pkg.sv
// Shared definitions for the cassette player: FSK half-cycle defaults and FSM states.
package cas_pkg;

  localparam int HALF0_DEF  = 5966;
  localparam int HALF1_DEF  = 2983;
  localparam int CLK_ENA_HZ = 14318180;

  typedef enum logic [2:0] {IDLE, FETCH, LATCH, HI, LO, DONE} state_t;

endpackage

// File: rtl/dpram.sv
// Simple dual-port RAM: port a writes, port b reads with one clock of latency.
module dpram #(
  parameter int addr_width_g = 8,
  parameter int data_width_g = 8
) (
  input  logic                    clock,
  input  logic                    wren_a,
  input  logic [addr_width_g-1:0] address_a,
  input  logic [data_width_g-1:0] data_a,
  input  logic [addr_width_g-1:0] address_b,
  output logic [data_width_g-1:0] q_b
);

  logic [data_width_g-1:0] mem [0:(2**addr_width_g)-1];

  always_ff @(posedge clock) begin
    if (wren_a) mem[address_a] <= data_a;
    q_b <= mem[address_b];
  end

endmodule

// File: rtl/fsk_bit_gen.sv
// Per-byte FSK timing: shift register, bit counter and half-cycle down-counter.
module fsk_bit_gen
  import cas_pkg::*;
#(
  parameter int HALF0 = HALF0_DEF,
  parameter int HALF1 = HALF1_DEF,
  parameter int CNT_W = 13
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       byte_ready,
  input  logic       step_hi,
  input  logic       step_lo,
  input  logic [7:0] data,
  output logic       half_end,
  output logic       byte_done
);

  logic [CNT_W-1:0] cnt;
  logic [2:0]       bitcnt;
  logic [7:0]       shreg;

  function automatic logic [CNT_W-1:0] half_ticks(input logic b);
    return b ? CNT_W'(HALF1 - 1) : CNT_W'(HALF0 - 1);
  endfunction

  assign half_end  = (cnt == '0);
  assign byte_done = half_end && (bitcnt == 3'd7);

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt    <= '0;
      bitcnt <= '0;
    end else if (byte_ready) begin
      cnt    <= half_ticks(data[0]);
      bitcnt <= '0;
    end else if (step_hi) begin
      cnt <= half_end ? half_ticks(shreg[0]) : cnt - CNT_W'(1);
    end else if (step_lo) begin
      if (!half_end) begin
        cnt <= cnt - CNT_W'(1);
      end else if (bitcnt != 3'd7) begin
        cnt    <= half_ticks(shreg[1]);
        bitcnt <= bitcnt + 3'd1;
      end
    end
  end

  // Data path carries no reset; every byte is reloaded before use.
  always_ff @(posedge clk) begin
    if (byte_ready) shreg <= data;
    else if (step_lo && half_end && bitcnt != 3'd7) shreg <= {1'b0, shreg[7:1]};
  end

endmodule

// File: rtl/cas_player.sv
// Cassette player: stores a .CAS image from ioctl and replays it as CoCo FSK audio.
module cas_player
  import cas_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int HALF0  = HALF0_DEF,
  parameter int HALF1  = HALF1_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_ena,
  input  logic              ioctl_download,
  input  logic              ioctl_cas,
  input  logic              ioctl_wr,
  input  logic [15:0]       ioctl_addr,
  input  logic [7:0]        ioctl_data,
  input  logic              motor,
  input  logic              rewind,
  output logic              cas_bit,
  output logic              playing,
  output logic              eot,
  output logic [ADDR_W-1:0] tape_pos
);

  localparam int          LW    = ADDR_W + 1;
  localparam int          CNT_W = $clog2((HALF0 > HALF1 ? HALF0 : HALF1) + 1);
  localparam logic [16:0] CAP   = 17'd1 << ADDR_W;

  state_t          state, state_nx;
  logic            dl, dl_p1, dl_rise, wr_en, in_range, last_byte;
  logic [16:0]     addr_p1;
  logic [LW-1:0]   tape_len, len_base, len_new;
  logic [7:0]      q;
  logic            gen_load, gen_step_hi, gen_step_lo, half_end, byte_done;

  function automatic logic [LW-1:0] len_max(input logic [LW-1:0] a, input logic [LW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  assign dl        = ioctl_download & ioctl_cas;
  assign dl_rise   = dl & ~dl_p1;
  assign addr_p1   = {1'b0, ioctl_addr} + 17'd1;
  assign in_range  = {1'b0, ioctl_addr} < CAP;
  assign wr_en     = ioctl_wr & dl & in_range;
  assign len_base  = dl_rise ? '0 : tape_len;
  assign len_new   = LW'(addr_p1);
  assign last_byte = ({1'b0, tape_pos} + LW'(1)) == tape_len;

  dpram #(.addr_width_g(ADDR_W), .data_width_g(8)) tape_buf (
    .clock     (clk),
    .wren_a    (wr_en),
    .address_a (ioctl_addr[ADDR_W-1:0]),
    .data_a    (ioctl_data),
    .address_b (tape_pos),
    .q_b       (q)
  );

  fsk_bit_gen #(.HALF0(HALF0), .HALF1(HALF1), .CNT_W(CNT_W)) bit_gen (
    .clk        (clk),
    .reset      (reset),
    .byte_ready (gen_load),
    .step_hi    (gen_step_hi),
    .step_lo    (gen_step_lo),
    .data       (q),
    .half_end   (half_end),
    .byte_done  (byte_done)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (dl || rewind) begin
      state_nx = IDLE;
    end else if (clk_ena) begin
      case (state)
        IDLE:    if (motor && tape_len != '0) state_nx = FETCH;
        FETCH:   state_nx = LATCH;
        LATCH:   state_nx = HI;
        HI:      if (motor && half_end) state_nx = LO;
        LO:      if (motor && half_end) state_nx = !byte_done ? HI : (last_byte ? DONE : FETCH);
        DONE:    state_nx = DONE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // LATCH completes regardless of motor; the counter then waits in HI.
  always_comb begin
    cas_bit     = (state == HI) && !dl;
    eot         = (state == DONE);
    gen_load    = clk_ena && (state == LATCH);
    gen_step_hi = clk_ena && motor && (state == HI);
    gen_step_lo = clk_ena && motor && (state == LO);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      dl_p1    <= 1'b0;
      tape_len <= '0;
      tape_pos <= '0;
      playing  <= 1'b0;
    end else begin
      dl_p1 <= dl;
      if (wr_en)        tape_len <= len_max(len_base, len_new);
      else if (dl_rise) tape_len <= '0;
      if (dl_rise || rewind)             tape_pos <= '0;
      else if (gen_step_lo && byte_done) tape_pos <= tape_pos + ADDR_W'(1);
      playing <= motor && (tape_len != '0) && (state != DONE) && !dl;
    end
  end

endmodule
